// File: rtl/if_stage_bp.sv
// if_stage_bp: MIPS instruction fetch stage with IF/ID register
// and a 2-bit saturating-counter branch history table.
module if_stage_bp #(
    parameter int              PC_W     = 32,
    parameter int              BHT_IDX  = 3,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic [31:0]     if_id_inst,
    output logic [PC_W-1:0] if_id_pc,
    output logic [PC_W-1:0] if_id_pc4,
    output logic            if_id_pred_taken,
    output logic            if_id_valid,
    output logic            id_flush,
    output logic [15:0]     mispredict_cnt
);

    localparam int BHT_N = 1 << BHT_IDX;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc4;
    logic [PC_W-1:0]    pred_target;
    logic [PC_W-1:0]    fix_pc;
    logic [PC_W-1:0]    imm_ext;
    logic [5:0]         opcode;
    logic               is_br;
    logic               pred_taken;
    logic               mispredict;
    logic [BHT_IDX-1:0] if_idx;
    logic [BHT_IDX-1:0] ex_idx;

    logic [1:0]         bht_q [BHT_N];
    logic [1:0]         bht_d [BHT_N];

    logic [31:0]        inst_q, inst_d;
    logic [PC_W-1:0]    ifpc_q, ifpc_d;
    logic [PC_W-1:0]    ifpc4_q, ifpc4_d;
    logic               pred_q, pred_d;
    logic               valid_q, valid_d;
    logic [15:0]        cnt_q, cnt_d;

    // rs/rt fields are not needed to predict a branch
    logic               unused_rdata;
    assign unused_rdata = ^imem_rdata[25:16];

    // Early decode of the fetched word and BHT lookup
    always_comb begin
        opcode      = imem_rdata[31:26];
        is_br       = (opcode == 6'b000100) || (opcode == 6'b000101);
        pc4         = pc_q + PC_W'(4);
        imm_ext     = {{(PC_W-18){imem_rdata[15]}}, imem_rdata[15:0], 2'b00};
        pred_target = pc4 + imm_ext;
        if_idx      = pc_q[BHT_IDX+1:2];
        pred_taken  = is_br && bht_q[if_idx][1];
    end

    // EX-stage resolution: detect a wrong guess and pick the repair PC
    always_comb begin
        ex_idx     = ex_pc[BHT_IDX+1:2];
        mispredict = ex_is_branch && (ex_taken != ex_pred_taken);
        fix_pc     = ex_taken ? ex_target : (ex_pc + PC_W'(4));
    end

    // Next PC: repair beats stall beats predicted-taken beats sequential
    always_comb begin
        pc_d = pc4;
        if (mispredict) begin
            pc_d = fix_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // IF/ID register: squash on repair, hold on stall, else load
    always_comb begin
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        pred_d  = pred_q;
        valid_d = valid_q;
        if (mispredict) begin
            inst_d  = '0;
            ifpc_d  = '0;
            ifpc4_d = '0;
            pred_d  = 1'b0;
            valid_d = 1'b0;
        end else if (!stall) begin
            inst_d  = imem_rdata;
            ifpc_d  = pc_q;
            ifpc4_d = pc4;
            pred_d  = pred_taken;
            valid_d = 1'b1;
        end
    end

    // Train the resolved branch's counter; stall does not block training
    always_comb begin
        for (int i = 0; i < BHT_N; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (ex_is_branch) begin
            if (ex_taken) begin
                if (bht_q[ex_idx] != 2'b11) begin
                    bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
                end
            end else begin
                if (bht_q[ex_idx] != 2'b00) begin
                    bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
                end
            end
        end
    end

    // Saturating count of repairs
    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // PC and IF/ID state
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            pred_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            pred_q  <= pred_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // BHT counters; reset to weakly not-taken
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    assign imem_addr        = pc_q;
    assign if_id_inst       = inst_q;
    assign if_id_pc         = ifpc_q;
    assign if_id_pc4        = ifpc4_q;
    assign if_id_pred_taken = pred_q;
    assign if_id_valid      = valid_q;
    assign id_flush         = mispredict;
    assign mispredict_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage_bp.sv
// tb_if_stage_bp: directed scoreboard bench for if_stage_bp.
// A reference model queues expected IF/ID contents per edge.
module tb_if_stage_bp;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_pred_taken;
    logic        if_id_valid;
    logic        id_flush;
    logic [15:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pred;
        logic        valid;
        logic [15:0] cnt;
        logic [31:0] addr;
    } exp_t;

    exp_t q [$];

    logic [31:0] m_pc;
    logic [1:0]  m_bht [8];
    logic [15:0] m_cnt;
    logic [31:0] m_inst, m_ifpc, m_ifpc4;
    logic        m_pred, m_valid;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    if_stage_bp dut (
        .clk              (clk),
        .clr              (clr),
        .stall            (stall),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .if_id_inst       (if_id_inst),
        .if_id_pc         (if_id_pc),
        .if_id_pc4        (if_id_pc4),
        .if_id_pred_taken (if_id_pred_taken),
        .if_id_valid      (if_id_valid),
        .id_flush         (id_flush),
        .mispredict_cnt   (mispredict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_cnt   = 16'h0;
        m_inst  = '0;
        m_ifpc  = '0;
        m_ifpc4 = '0;
        m_pred  = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_bht[i] = 2'b01;
        q.delete();
    endtask

    task automatic chk_reset_state();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_pred", 32'(if_id_pred_taken), 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_cnt", 32'(mispredict_cnt), 32'h0);
    endtask

    task automatic step(input logic st, input logic eb,
                        input logic [31:0] epc, input logic et,
                        input logic [31:0] etgt, input logic ep);
        exp_t        e;
        logic [31:0] inst, ptgt, fix;
        logic        isbr, pt, mis;
        logic [2:0]  ii, ei;
        stall         = st;
        ex_is_branch  = eb;
        ex_pc         = epc;
        ex_taken      = et;
        ex_target     = etgt;
        ex_pred_taken = ep;
        #1;
        inst = mem[m_pc[7:2]];
        isbr = (inst[31:26] == 6'b000100) || (inst[31:26] == 6'b000101);
        ptgt = m_pc + 32'd4 + {{14{inst[15]}}, inst[15:0], 2'b00};
        ii   = m_pc[4:2];
        ei   = epc[4:2];
        pt   = isbr && m_bht[ii][1];
        mis  = eb && (et != ep);
        fix  = et ? etgt : epc + 32'd4;
        chk("imem_addr", imem_addr, m_pc);
        chk("id_flush", 32'(id_flush), 32'(mis));
        if (mis) begin
            m_inst = '0; m_ifpc = '0; m_ifpc4 = '0;
            m_pred = 1'b0; m_valid = 1'b0;
        end else if (!st) begin
            m_inst = inst; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
            m_pred = pt; m_valid = 1'b1;
        end
        if (mis) m_pc = fix;
        else if (st) m_pc = m_pc;
        else if (pt) m_pc = ptgt;
        else m_pc = m_pc + 32'd4;
        if (eb) begin
            if (et && m_bht[ei] != 2'b11) m_bht[ei] = m_bht[ei] + 2'd1;
            if (!et && m_bht[ei] != 2'b00) m_bht[ei] = m_bht[ei] - 2'd1;
        end
        if (mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        e.inst = m_inst; e.pc = m_ifpc; e.pc4 = m_ifpc4;
        e.pred = m_pred; e.valid = m_valid; e.cnt = m_cnt;
        e.addr = m_pc;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("if_id_inst", if_id_inst, e.inst);
        chk("if_id_pc", if_id_pc, e.pc);
        chk("if_id_pc4", if_id_pc4, e.pc4);
        chk("if_id_pred", 32'(if_id_pred_taken), 32'(e.pred));
        chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        chk("mis_cnt", 32'(mispredict_cnt), 32'(e.cnt));
        chk("next_addr", imem_addr, e.addr);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {6'b001000, 26'(i)};
        mem[4] = 32'h1000_0004;
        clr = 1'b1;
        stall = 1'b0;
        ex_is_branch = 1'b0;
        ex_pc = '0;
        ex_taken = 1'b0;
        ex_target = '0;
        ex_pred_taken = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_state();
        clr = 1'b0;

        idle();
        chk("first_valid", 32'(if_id_valid), 32'h1);
        idle();
        chk("seq_addr8", imem_addr, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_ifpc", if_id_pc, 32'h4);
        idle();
        chk("resume_addr", imem_addr, 32'hC);
        idle();
        idle();
        chk("beq_nt_pred", 32'(if_id_pred_taken), 32'h0);
        chk("beq_nt_addr", imem_addr, 32'h14);
        idle();

        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h24, 1'b0);
        chk("mis1_addr", imem_addr, 32'h24);
        chk("mis1_valid", 32'(if_id_valid), 32'h0);
        chk("mis1_cnt", 32'(mispredict_cnt), 32'h1);

        step(1'b0, 1'b1, 32'h08, 1'b1, 32'h10, 1'b0);
        idle();
        chk("beq_t_addr", imem_addr, 32'h24);
        chk("beq_t_pred", 32'(if_id_pred_taken), 32'h1);
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h24, 1'b1);
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h24, 1'b1);

        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
        chk("mis_st_addr", imem_addr, 32'h14);
        chk("mis_st_valid", 32'(if_id_valid), 32'h0);

        step(1'b0, 1'b1, 32'h08, 1'b1, 32'h10, 1'b0);
        idle();
        chk("w10_addr", imem_addr, 32'h24);
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h24, 1'b0);
        step(1'b0, 1'b1, 32'h08, 1'b1, 32'h10, 1'b0);
        step(1'b0, 1'b1, 32'h30, 1'b1, 32'h0, 1'b1);
        chk("rw_old_pred", 32'(if_id_pred_taken), 32'h0);
        chk("rw_old_addr", imem_addr, 32'h14);
        step(1'b0, 1'b1, 32'h08, 1'b1, 32'h10, 1'b0);
        idle();
        chk("rw_new_addr", imem_addr, 32'h24);
        chk("cnt_8", 32'(mispredict_cnt), 32'h8);

        stall = 1'b0;
        ex_is_branch = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        chk_reset_state();
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        repeat (4) idle();
        idle();
        chk("post_rst_pred", 32'(if_id_pred_taken), 32'h0);
        chk("post_rst_addr", imem_addr, 32'h14);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_bp.md
Name: if_stage_bp

Overview:
Instruction-fetch stage plus IF/ID pipeline register with dynamic branch prediction for the 5-stage MIPS pipeline.
- Holds the PC and indexes a 2-bit-counter branch history table (BHT).
- Predicts beq/bne in IF, fetches from the predicted path, and redirects/flushes on an EX-stage mispredict.
- Feeds the ID stage; the ID/EX control register downstream consumes id_flush.

Parameters:
PC_W, 32, PC/address width
BHT_IDX, 3, BHT index bits (2^BHT_IDX entries, indexed by pc[BHT_IDX+1:2])
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  reset, asynchronous, active-high
stall  in  1  load-use stall from hazard unit; hold PC and IF/ID
imem_addr  out  PC_W  instruction memory address (= pc, combinational)
imem_rdata  in  32  instruction from combinational instruction memory
ex_is_branch  in  1  EX stage holds a valid beq/bne
ex_pc  in  PC_W  PC of the EX branch
ex_taken  in  1  resolved outcome
ex_target  in  PC_W  resolved branch target
ex_pred_taken  in  1  prediction carried with the EX branch
if_id_inst  out  32  IF/ID instruction
if_id_pc  out  PC_W  IF/ID PC
if_id_pc4  out  PC_W  IF/ID PC+4
if_id_pred_taken  out  1  prediction made for if_id_inst
if_id_valid  out  1  0 = bubble
id_flush  out  1  combinational; squash ID/EX on next edge
mispredict_cnt  out  16  saturating mispredict counter

Behaviour:
- Reset (clr=1, async):
  - pc=RESET_PC.
  - if_id_inst=0, if_id_pc=0, if_id_pc4=0, if_id_pred_taken=0, if_id_valid=0.
  - All BHT entries=2'b01 (weakly not-taken).
  - mispredict_cnt=0.
  - Reset mid-operation discards all in-flight state; the first fetch after release is RESET_PC.
- IF decode of imem_rdata:
  - is_br = opcode[31:26] is 6'b000100 or 6'b000101.
  - pred_target = pc+4 + (sign-extended imm[15:0] << 2), PC_W-bit wrap-around arithmetic.
  - pred_taken = is_br & BHT[pc idx][1].
- mispredict = ex_is_branch & (ex_taken != ex_pred_taken).
  - fix_pc = ex_taken ? ex_target : ex_pc+4.
- Next-PC priority, highest first:
  1. mispredict → fix_pc
  2. stall → pc (hold)
  3. pred_taken → pred_target
  4. else → pc+4
- IF/ID update on each edge:
  - mispredict: inst=0 (nop), pc/pc4/pred=0, valid=0. This applies even if stall=1; mispredict wins.
  - else stall: hold all IF/ID fields.
  - else: inst=imem_rdata, pc=pc, pc4=pc+4, pred_taken=pred_taken, valid=1.
- id_flush = mispredict. Two wrong-path instructions (IF and ID) are squashed, giving a 2-cycle penalty; a correct prediction costs 0 cycles.
- BHT update:
  - Every edge with ex_is_branch=1, regardless of stall, at index ex_pc[BHT_IDX+1:2].
  - Saturating: taken → +1 capped at 3; not taken → −1 floored at 0.
- Same-cycle BHT read and update of one entry: the IF read sees the old value; the new value is visible the next cycle.
- mispredict_cnt: +1 per mispredict edge; saturates at 16'hFFFF, no wrap.
- Latency: an instruction appears on IF/ID one edge after its PC is presented on imem_addr.
- Non-branch opcodes never consult the BHT; they are always predicted not-taken.

Test Plan:
- Reset release, sequential non-branch program, stall=0 → imem_addr 0,4,8,C on successive cycles; if_id_valid=1 from the 1st edge; if_id_pc lags imem_addr by 1 cycle.
- stall=1 for 2 cycles at pc=8 → pc held at 8 and IF/ID held holding the pc=4 instruction; resumes at C once stall drops.
- beq at 0x10, imm=4, BHT entry=01, EX later reports taken with pred=0, ex_target=0x24 → id_flush=1 for one cycle; next imem_addr=0x24; IF/ID bubble (valid=0, inst=0); mispredict_cnt=1; entry becomes 10.
- Same beq fetched again (entry 10) → pred_taken=1; next imem_addr=0x24 directly; EX taken with pred=1 → no flush; entry becomes 11, then stays 11 on further taken outcomes.
- Mispredict (not taken, pred=1, ex_pc=0x10) with stall=1 in the same cycle → imem_addr=0x14; IF/ID bubble; stall ignored; entry decrements 11 → 10.
- clr asserted mid-stream between clock edges → outputs zero immediately; pc=RESET_PC; all BHT entries back to 01 (a previously trained branch now predicted not-taken).
